// File: rtl/imem_pkg.sv
// Shared constants, FSM state type and address-wrap helper for the instruction memory responder.
package imem_pkg;

    localparam int IMEM_DEPTH = 32;
    localparam int IMEM_AW    = $clog2(IMEM_DEPTH);
    localparam int INST_W     = 32;
    localparam logic [INST_W-1:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RESP = 2'd1,
        ST_HALT = 2'd2
    } imem_state_t;

    function automatic int wrap_addr(input int addr, input int depth);
        return addr % depth;
    endfunction

endpackage

// File: rtl/imem_array.sv
// Instruction storage: synchronous write, registered read, cleared by reset.
// With IMEM_PARITY_EN defined, one even-parity bit per word is kept and checked on read.
module imem_array
    import imem_pkg::*;
#(
    parameter int   DEPTH = IMEM_DEPTH,
    localparam int  AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_wr_en,
    input  logic [AW-1:0]     i_wr_addr,
    input  logic [INST_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic [AW-1:0]     i_rd_addr,
`ifdef IMEM_PARITY_EN
    output logic              o_parity_err,
`endif
    output logic [INST_W-1:0] o_rd_data
);

    logic [INST_W-1:0] r_mem [DEPTH];
    logic [INST_W-1:0] r_rd_data;
    logic [AW-1:0]     w_wr_idx;
    logic [AW-1:0]     w_rd_idx;

    assign w_wr_idx  = AW'(wrap_addr(int'(i_wr_addr), DEPTH));
    assign w_rd_idx  = AW'(wrap_addr(int'(i_rd_addr), DEPTH));
    assign o_rd_data = r_rd_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_rd_data <= '0;
        end else begin
            if (i_wr_en) r_mem[w_wr_idx] <= i_wr_data;
            if (i_rd_en) r_rd_data <= r_mem[w_rd_idx];
        end
    end

`ifdef IMEM_PARITY_EN
    // Stored bit makes word+bit carry an even number of ones; all-zero reset is consistent.
    logic r_par [DEPTH];
    logic r_parity_err;

    assign o_parity_err = r_parity_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_par[i] <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            if (i_wr_en) r_par[w_wr_idx] <= ^i_wr_data;
            if (i_rd_en) r_parity_err <= (^r_mem[w_rd_idx]) != r_par[w_rd_idx];
        end
    end
`endif

endmodule

// File: rtl/imem_responder.sv
// Instruction-fetch responder: one-cycle registered reads, response backpressure, halt on HALT_WORD.
// Optional parity checking is enabled by defining IMEM_PARITY_EN.
//   state | meaning
//   IDLE  | no response outstanding, ready for a fetch
//   RESP  | resp_inst valid, waiting for resp_ready
//   HALT  | HALT_WORD delivered, fetch frozen until resume
module imem_responder
    import imem_pkg::*;
#(
    parameter int                DEPTH     = IMEM_DEPTH,
    parameter logic [INST_W-1:0] HALT_WORD = HALT_WORD_DEFAULT,
    localparam int               AW        = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic [AW-1:0]     req_addr,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [INST_W-1:0] resp_inst,
    input  logic              resp_ready,
    input  logic              load_en,
    input  logic [AW-1:0]     load_addr,
    input  logic [INST_W-1:0] load_data,
`ifdef IMEM_PARITY_EN
    output logic              parity_err,
`endif
    output logic              halted,
    input  logic              resume
);

    imem_state_t       r_state;
    logic              w_accept;
    logic              w_wr_en;
    logic              w_resp_is_halt;
    logic [INST_W-1:0] w_rd_data;

    assign w_resp_is_halt = (w_rd_data == HALT_WORD);
    assign req_ready = !load_en &&
                       ((r_state == ST_IDLE) ||
                        (r_state == ST_RESP && resp_ready && !w_resp_is_halt));
    assign w_accept  = req_valid && req_ready;
    // Collision guard is structurally redundant (load_en blocks acceptance) but states the rule.
    assign w_wr_en   = load_en &&
                       !(w_accept && (wrap_addr(int'(load_addr), DEPTH) == wrap_addr(int'(req_addr), DEPTH)));

    assign resp_valid = (r_state == ST_RESP);
    assign halted     = (r_state == ST_HALT);
    assign resp_inst  = w_rd_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (w_accept) r_state <= ST_RESP;
                ST_RESP: begin
                    if (resp_ready) begin
                        if (w_resp_is_halt) r_state <= ST_HALT;
                        else if (!w_accept) r_state <= ST_IDLE;
                    end
                end
                ST_HALT: if (resume) r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    imem_array #(.DEPTH(DEPTH)) u_array (
        .clk          (clk),
        .rst_n        (reset),
        .i_wr_en      (w_wr_en),
        .i_wr_addr    (load_addr),
        .i_wr_data    (load_data),
        .i_rd_en      (w_accept),
        .i_rd_addr    (req_addr),
`ifdef IMEM_PARITY_EN
        .o_parity_err (parity_err),
`endif
        .o_rd_data    (w_rd_data)
    );

endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder: directed scenarios plus a randomized run against
// a transaction-level model (memory array, pending response, halted flag).
module tb_imem_responder;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [4:0]  req_addr;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_inst;
    logic        resp_ready;
    logic        load_en;
    logic [4:0]  load_addr;
    logic [31:0] load_data;
    logic        halted;
    logic        resume;
`ifdef IMEM_PARITY_EN
    logic        parity_err;
`endif

    int errors = 0;
    int checks = 0;
    logic [31:0] model_mem [32];

    always #5 clk = ~clk;

    imem_responder dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_inst  (resp_inst),
        .resp_ready (resp_ready),
        .load_en    (load_en),
        .load_addr  (load_addr),
        .load_data  (load_data),
`ifdef IMEM_PARITY_EN
        .parity_err (parity_err),
`endif
        .halted     (halted),
        .resume     (resume)
    );

    task automatic do_load(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        load_en = 1'b1; load_addr = a; load_data = d;
        #1;
        checks++;
        if (req_ready !== 1'b0) begin
            errors++; $display("FAIL load_blocks_ready: got %b want 0", req_ready);
        end
        @(negedge clk);
        load_en = 1'b0;
        model_mem[a] = d;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (resp_valid !== 1'b0 || halted !== 1'b0 || resp_inst !== 32'h0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: valid=%b halted=%b inst=%h ready=%b want 0 0 0 1",
                     resp_valid, halted, resp_inst, req_ready);
        end
        load_en = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b0) begin
            errors++; $display("FAIL reset_load_ready: got %b want 0", req_ready);
        end
        load_en = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 32; i++) model_mem[i] = 32'h0;
    endtask

    task automatic test_unloaded();
        @(negedge clk);
        req_valid = 1'b1; req_addr = 5'd20; resp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        checks++;
        if (resp_valid !== 1'b1 || resp_inst !== 32'h0) begin
            errors++; $display("FAIL unloaded_read: valid=%b inst=%h want 1 00000000", resp_valid, resp_inst);
        end
        @(negedge clk);
    endtask

    task automatic test_load_fetch();
        do_load(5'd5, 32'h2002_000A);
        req_valid = 1'b1; req_addr = 5'd5; resp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL fetch_ready: got %b want 1", req_ready);
        end
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        checks++;
        if (resp_valid !== 1'b1 || resp_inst !== 32'h2002_000A) begin
            errors++; $display("FAIL fetch_addr5: valid=%b inst=%h want 1 2002000a", resp_valid, resp_inst);
        end
        @(negedge clk);
        #1;
        checks++;
        if (resp_valid !== 1'b0) begin
            errors++; $display("FAIL fetch_to_idle: valid=%b want 0", resp_valid);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) do_load(5'(i), $urandom() & 32'h7FFF_FFFF);
        resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_valid = (i < 3); req_addr = 5'(i);
            #1;
            if (i < 3) begin
                checks++;
                if (req_ready !== 1'b1) begin
                    errors++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, req_ready);
                end
            end
            if (i > 0) begin
                checks++;
                if (resp_valid !== 1'b1 || resp_inst !== model_mem[i-1]) begin
                    errors++;
                    $display("FAIL b2b_resp[%0d]: valid=%b inst=%h want 1 %h", i-1, resp_valid, resp_inst, model_mem[i-1]);
                end
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [31:0] d;
        d = $urandom() & 32'h7FFF_FFFF;
        do_load(5'd9, d);
        req_valid = 1'b1; req_addr = 5'd9; resp_ready = 1'b0;
        @(negedge clk);
        req_addr = 5'd5;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (resp_valid !== 1'b1 || resp_inst !== d || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold[%0d]: valid=%b inst=%h ready=%b want 1 %h 0", i, resp_valid, resp_inst, req_ready, d);
            end
            @(negedge clk);
        end
        req_valid = 1'b0; resp_ready = 1'b1;
        #1;
        checks++;
        if (resp_inst !== d || req_ready !== 1'b1) begin
            errors++; $display("FAIL handoff: inst=%h ready=%b want %h 1", resp_inst, req_ready, d);
        end
        @(negedge clk);
        #1;
        checks++;
        if (resp_valid !== 1'b0) begin
            errors++; $display("FAIL single_handoff: valid=%b want 0", resp_valid);
        end
    endtask

    task automatic test_halt();
        do_load(5'd3, HALT);
        req_valid = 1'b1; req_addr = 5'd3; resp_ready = 1'b1;
        @(negedge clk);
        req_addr = 5'd0;
        #1;
        checks++;
        if (resp_valid !== 1'b1 || resp_inst !== HALT || req_ready !== 1'b0) begin
            errors++; $display("FAIL halt_word_resp: valid=%b inst=%h ready=%b want 1 ffffffff 0", resp_valid, resp_inst, req_ready);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (halted !== 1'b1 || resp_valid !== 1'b0 || req_ready !== 1'b0) begin
                errors++; $display("FAIL halted[%0d]: halted=%b valid=%b ready=%b want 1 0 0", i, halted, resp_valid, req_ready);
            end
        end
        req_valid = 1'b0; resume = 1'b1;
        @(negedge clk);
        resume = 1'b0;
        #1;
        checks++;
        if (halted !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL resume: halted=%b valid=%b ready=%b want 0 0 1", halted, resp_valid, req_ready);
        end
    endtask

    task automatic test_reset_mid_resp();
        do_load(5'd5, 32'h2002_000A);
        req_valid = 1'b1; req_addr = 5'd5; resp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (resp_valid !== 1'b0 || halted !== 1'b0 || resp_inst !== 32'h0) begin
            errors++; $display("FAIL reset_mid_resp: valid=%b halted=%b inst=%h want 0 0 0", resp_valid, halted, resp_inst);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 32; i++) model_mem[i] = 32'h0;
        resp_ready = 1'b1; req_valid = 1'b1; req_addr = 5'd5;
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        checks++;
        if (resp_valid !== 1'b1 || resp_inst !== 32'h0) begin
            errors++; $display("FAIL reread_after_reset: valid=%b inst=%h want 1 00000000", resp_valid, resp_inst);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        bit          pending = 1'b0;
        bit          m_halted = 1'b0;
        logic [31:0] pend_inst = 32'h0;
        bit          exp_ready;
        bit          consumed;
        for (int cyc = 0; cyc < 400; cyc++) begin
            req_valid  = ($urandom_range(0, 2) != 0);
            req_addr   = 5'($urandom_range(0, 15));
            resp_ready = ($urandom_range(0, 3) != 0);
            load_en    = ($urandom_range(0, 5) == 0);
            load_addr  = 5'($urandom_range(0, 15));
            load_data  = ($urandom_range(0, 7) == 0) ? HALT : $urandom();
            resume     = ($urandom_range(0, 3) == 0);
            exp_ready  = !load_en && !m_halted && (!pending || (resp_ready && pend_inst != HALT));
            #1;
            checks++;
            if (resp_valid !== pending || halted !== m_halted || req_ready !== exp_ready ||
                (pending && resp_inst !== pend_inst)) begin
                errors++;
                $display("FAIL random[%0d]: valid=%b halted=%b ready=%b inst=%h want %b %b %b %h",
                         cyc, resp_valid, halted, req_ready, resp_inst, pending, m_halted, exp_ready, pend_inst);
            end
            consumed = pending && resp_ready;
            if (m_halted) begin
                if (resume) m_halted = 1'b0;
            end else if (consumed && pend_inst == HALT) begin
                m_halted = 1'b1;
                pending  = 1'b0;
            end else if (req_valid && exp_ready) begin
                pending   = 1'b1;
                pend_inst = model_mem[req_addr];
            end else if (consumed) begin
                pending = 1'b0;
            end
            if (load_en) model_mem[load_addr] = load_data;
            @(negedge clk);
        end
        load_en = 1'b0; req_valid = 1'b0; resume = 1'b0;
    endtask

`ifdef IMEM_PARITY_EN
    task automatic test_parity();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        do_load(5'd7, 32'h1234_5678);
        do_load(5'd8, 32'h0F0F_0001);
        dut.u_array.r_mem[7][4] = ~dut.u_array.r_mem[7][4];
        req_valid = 1'b1; req_addr = 5'd7; resp_ready = 1'b1;
        @(negedge clk);
        req_addr = 5'd8;
        #1;
        checks++;
        if (resp_valid !== 1'b1 || parity_err !== 1'b1) begin
            errors++; $display("FAIL parity_corrupt: valid=%b perr=%b want 1 1", resp_valid, parity_err);
        end
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        checks++;
        if (resp_valid !== 1'b1 || parity_err !== 1'b0 || resp_inst !== 32'h0F0F_0001) begin
            errors++; $display("FAIL parity_clean: valid=%b perr=%b inst=%h want 1 0 0f0f0001", resp_valid, parity_err, resp_inst);
        end
        @(negedge clk);
    endtask
`endif

    initial begin
        reset = 1'b0; req_valid = 1'b0; req_addr = '0; resp_ready = 1'b0;
        load_en = 1'b0; load_addr = '0; load_data = '0; resume = 1'b0;
        for (int i = 0; i < 32; i++) model_mem[i] = 32'h0;
        repeat (2) @(negedge clk);
        test_reset();
        test_unloaded();
        test_load_fetch();
        test_back_to_back();
        test_backpressure();
        test_halt();
        test_reset_mid_resp();
        test_random();
`ifdef IMEM_PARITY_EN
        test_parity();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
